// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory-side responder.
package mem_resp_pkg;

  localparam int unsigned LATBITS = 8;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Synchronous single-port RAM: one read or one write per cycle, array not reset.
module sp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services one read/write at a time from internal RAM
// after a programmable latency, standing in for external memory below the cache.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned MEMADDRBITS = 10,
  parameter int unsigned RDLAT       = 4,
  parameter int unsigned WRLAT       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] mem_addr,
  input  logic [DATABITS-1:0] mem_in,
  input  logic                mem_wrreq,
  input  logic                mem_rdreq,
  output logic [DATABITS-1:0] mem_out,
  output logic                mem_out_valid,
  output logic                busy
);

  if (RDLAT < 1 || RDLAT > 255) begin : g_bad_rdlat
    $error("mem_responder: RDLAT must be in 1..255");
  end
  if (WRLAT < 1 || WRLAT > 255) begin : g_bad_wrlat
    $error("mem_responder: WRLAT must be in 1..255");
  end

  localparam logic [LATBITS-1:0] RD_CNT = LATBITS'(RDLAT - 1);
  localparam logic [LATBITS-1:0] WR_CNT = LATBITS'(WRLAT - 1);

  state_t                 state, state_next;
  logic [LATBITS-1:0]     cnt;
  logic                   req_type;
  logic [MEMADDRBITS-1:0] req_idx;
  logic [DATABITS-1:0]    req_data;

  logic                   accept;
  logic                   finish;
  logic                   ram_we;
  logic [MEMADDRBITS-1:0] addr_idx;
  logic [MEMADDRBITS-1:0] ram_addr;
  logic [DATABITS-1:0]    ram_rdata;
  logic                   addr_unused;

  assign addr_idx    = mem_addr[MEMADDRBITS+1:2];
  assign addr_unused = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};

  assign accept = (state == IDLE) && (mem_wrreq || mem_rdreq);
  assign finish = (state == WAIT) && (cnt == '0);

  // RAM reads the incoming word while idle so data is ready even for a latency of 1.
  assign ram_addr = (state == IDLE) ? addr_idx : req_idx;
  assign ram_we   = !reset && finish && (req_type == REQ_WR);

  sp_ram #(
    .DEPTH (2 ** MEMADDRBITS),
    .WIDTH (DATABITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      req_type      <= REQ_RD;
      req_idx       <= '0;
      req_data      <= '0;
      mem_out       <= '0;
      mem_out_valid <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        // Write wins when both requests are raised together.
        req_type      <= mem_wrreq ? REQ_WR : REQ_RD;
        req_idx       <= addr_idx;
        req_data      <= mem_in;
        cnt           <= mem_wrreq ? WR_CNT : RD_CNT;
        busy          <= 1'b1;
        mem_out_valid <= 1'b0;
      end else if (state == WAIT) begin
        if (finish) begin
          busy          <= 1'b0;
          mem_out_valid <= 1'b1;
          if (req_type == REQ_RD) mem_out <= ram_rdata;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (RDLAT=4, WRLAT=2).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic        mem_wrreq;
  logic        mem_rdreq;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic        busy;

  int passed = 0;
  int total  = 0;

  mem_responder #(
    .ADDRBITS    (32),
    .DATABITS    (32),
    .MEMADDRBITS (10),
    .RDLAT       (4),
    .WRLAT       (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_in        (mem_in),
    .mem_wrreq     (mem_wrreq),
    .mem_rdreq     (mem_rdreq),
    .mem_out       (mem_out),
    .mem_out_valid (mem_out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request from IDLE, check every cycle until it is back in IDLE.
  task automatic do_req(input string tag, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int lat, input logic [31:0] exp_out);
    mem_addr  = addr;
    mem_in    = data;
    mem_wrreq = wr;
    mem_rdreq = rd;
    tick();
    mem_wrreq = 1'b0;
    mem_rdreq = 1'b0;
    check({tag, "_accept_valid"}, 32'(mem_out_valid), 32'd0);
    check({tag, "_accept_busy"},  32'(busy),          32'd1);
    for (int i = 1; i < lat; i++) begin
      tick();
      check({tag, "_wait_valid"}, 32'(mem_out_valid), 32'd0);
    end
    tick();
    check({tag, "_done_valid"}, 32'(mem_out_valid), 32'd1);
    check({tag, "_done_busy"},  32'(busy),          32'd0);
    check({tag, "_done_out"},   mem_out,            exp_out);
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    mem_addr  = '0;
    mem_in    = '0;
    mem_wrreq = 1'b0;
    mem_rdreq = 1'b0;

    // 1. reset then idle
    tick();
    tick();
    reset = 1'b0;
    check("rst_out",   mem_out,              32'h0);
    check("rst_valid", 32'(mem_out_valid),   32'd1);
    check("rst_busy",  32'(busy),            32'd0);
    tick();
    check("idle_valid", 32'(mem_out_valid),  32'd1);

    // 2. write then read with aliased upper bit
    do_req("wr0", 1'b1, 1'b0, 32'h8000_0000, 32'h0fff_0001, 2, 32'h0);
    do_req("rd0", 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4, 32'h0fff_0001);

    // 3. held read: one completion per 6 cycles
    do_req("wr1", 1'b1, 1'b0, 32'h8000_0004, 32'h1234_5678, 2, 32'h0fff_0001);
    mem_addr  = 32'h8000_0004;
    mem_rdreq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("held_valid", 32'(mem_out_valid), ((k % 6) >= 4) ? 32'd1 : 32'd0);
      check("held_busy",  32'(busy),          ((k % 6) <  4) ? 32'd1 : 32'd0);
      if ((k % 6) == 4) check("held_out", mem_out, 32'h1234_5678);
    end
    mem_rdreq = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("held_end_valid", 32'(mem_out_valid), 32'd1);
    check("held_end_busy",  32'(busy),          32'd0);

    // 4. simultaneous request: write wins, mem_out unchanged
    do_req("both", 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 2, 32'h1234_5678);
    do_req("rd100", 1'b0, 1'b1, 32'h0000_0100, 32'h0,       4, 32'h0000_0100);

    // 5. aliasing
    do_req("wr480", 1'b1, 1'b0, 32'h0000_0480, 32'hdead_beef, 2, 32'h0000_0100);
    do_req("rd480", 1'b0, 1'b1, 32'h8000_0480, 32'h0,        4, 32'hdead_beef);

    // 6. reset mid-write drops the write
    do_req("wr200", 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200, 2, 32'hdead_beef);
    mem_addr  = 32'h0000_0200;
    mem_in    = 32'h0000_0011;
    mem_wrreq = 1'b1;
    tick();
    mem_wrreq = 1'b0;
    check("abort_accept_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",  32'(busy),          32'd0);
    check("abort_valid", 32'(mem_out_valid), 32'd1);
    check("abort_out",   mem_out,            32'h0);
    tick();
    do_req("rd200", 1'b0, 1'b1, 32'h0000_0200, 32'h0, 4, 32'h0000_0200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
